ghost_collide: RTL and testbench

GHOST_COLLIDE -- requirements
Module: ghost_collide

---
 rtl/pacman_pkg.sv | 33 +++
 rtl/box_overlap.sv | 26 ++
 rtl/ghost_collide.sv | 136 +++++++++++++
 tb/tb_ghost_collide.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and defaults for the ghost/PacMan collision slice.
// GHOST_COLLIDE_GRACE_EN adds the post-catch GRACE state to collide_state_t.
package pacman_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned LIVES_W = 2;

  localparam int unsigned LIVES_DEFAULT = 3;
  localparam int unsigned HOLD_DEFAULT  = 60;
  localparam int unsigned GRACE_DEFAULT = 30;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    CAUGHT = 2'd1,
`ifdef GHOST_COLLIDE_GRACE_EN
    GRACE  = 2'd2,
`endif
    OVER   = 2'd3
  } collide_state_t;

  // Absolute difference widened by one bit so it never wraps.
  function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
    logic [COORD_W:0] wa;
    logic [COORD_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap between two centre/half-size boxes.
// Touching edges (distance equal to combined half-sizes) is not an overlap.
module box_overlap
  import pacman_pkg::*;
(
  input  coord_t a_x,
  input  coord_t a_y,
  input  coord_t a_s,
  input  coord_t b_x,
  input  coord_t b_y,
  input  coord_t b_s,
  output logic   overlap_c
);

  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic [COORD_W:0] reach;

  always_comb begin
    dx        = abs_diff(a_x, b_x);
    dy        = abs_diff(a_y, b_y);
    reach     = {1'b0, a_s} + {1'b0, b_s};
    overlap_c = (dx < reach) && (dy < reach);
  end

endmodule

// File: rtl/ghost_collide.sv
// Ghost/PacMan catch tracker: lives, freeze window and game-over flag.
// Define GHOST_COLLIDE_GRACE_EN to add a post-freeze grace window.
module ghost_collide
  import pacman_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = LIVES_DEFAULT,
  parameter int unsigned HOLD_FRAMES  = HOLD_DEFAULT,
  parameter int unsigned GRACE_FRAMES = GRACE_DEFAULT
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  coord_t             ghostX,
  input  coord_t             ghostY,
  input  coord_t             ghostS,
  input  coord_t             pacX,
  input  coord_t             pacY,
  input  coord_t             pacS,
  output logic               caught,
  output logic               freeze,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  // Elaboration-time parameter range guards.
  if (LIVES_INIT < 1 || LIVES_INIT > 3) begin : g_bad_lives
    $error("ghost_collide: LIVES_INIT out of range 1..3");
  end
  if (HOLD_FRAMES < 1 || HOLD_FRAMES > 1023) begin : g_bad_hold
    $error("ghost_collide: HOLD_FRAMES out of range 1..1023");
  end
  if (GRACE_FRAMES < 1 || GRACE_FRAMES > 1023) begin : g_bad_grace
    $error("ghost_collide: GRACE_FRAMES out of range 1..1023");
  end

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_FRAMES - 1);
`ifdef GHOST_COLLIDE_GRACE_EN
  localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_FRAMES - 1);
`endif

  collide_state_t     state_q;
  collide_state_t     state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [LIVES_W-1:0] lives_d;
  logic               caught_d;
  logic               freeze_d;
  logic               game_over_d;
  logic               overlap_c;

  box_overlap u_box_overlap (
    .a_x       (ghostX),
    .a_y       (ghostY),
    .a_s       (ghostS),
    .b_x       (pacX),
    .b_y       (pacY),
    .b_s       (pacS),
    .overlap_c (overlap_c)
  );

  // State, counter and registered outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= PLAY;
      cnt_q     <= '0;
      lives     <= LIVES_LOAD;
      caught    <= 1'b0;
      freeze    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives     <= lives_d;
      caught    <= caught_d;
      freeze    <= freeze_d;
      game_over <= game_over_d;
    end
  end

  // Next state; overlap only matters in PLAY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lives_d  = lives;
    caught_d = 1'b0;

    case (state_q)
      PLAY: begin
        if (overlap_c) begin
          caught_d = 1'b1;
          if (lives <= LIVES_W'(1)) begin
            lives_d = '0;
            cnt_d   = '0;
            state_d = OVER;
          end else begin
            lives_d = lives - LIVES_W'(1);
            cnt_d   = HOLD_LOAD;
            state_d = CAUGHT;
          end
        end
      end
      CAUGHT: begin
        if (cnt_q == '0) begin
`ifdef GHOST_COLLIDE_GRACE_EN
          cnt_d   = GRACE_LOAD;
          state_d = GRACE;
`else
          state_d = PLAY;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef GHOST_COLLIDE_GRACE_EN
      GRACE: begin
        if (cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
        cnt_d   = '0;
      end
    endcase

    freeze_d    = (state_d == CAUGHT) || (state_d == OVER);
    game_over_d = (state_d == OVER);
  end

endmodule

// File: tb/tb_ghost_collide.sv
// Self-checking bench for ghost_collide: directed scenarios plus random
// positions, checked every frame against a frame-index catch model.
module tb_ghost_collide;

  localparam int HOLD  = 60;
`ifdef GHOST_COLLIDE_GRACE_EN
  localparam int GRACE = 30;
`else
  localparam int GRACE = 0;
`endif
  localparam int PERIOD = HOLD + GRACE + 1;
  localparam int LIVES0 = 3;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] ghostX, ghostY, ghostS, pacX, pacY, pacS;
  logic       caught, freeze, game_over;
  logic [1:0] lives;

  ghost_collide #(.LIVES_INIT(3), .HOLD_FRAMES(60), .GRACE_FRAMES(30)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .ghostX    (ghostX),
    .ghostY    (ghostY),
    .ghostS    (ghostS),
    .pacX      (pacX),
    .pacY      (pacY),
    .pacS      (pacS),
    .caught    (caught),
    .freeze    (freeze),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: frame index of the last catch decides caught/freeze directly.
  int m_e, m_last, m_lives;
  bit m_has, m_over, m_ov;
  bit exp_caught, exp_freeze;
  int pulses = 0;
  int last_pulse_e = -100000;
  int gap = 0;

  function automatic bit model_ov(input int gx, input int gy, input int gs,
                                  input int px, input int py, input int ps);
    int dx, dy, reach;
    dx = (gx > px) ? gx - px : px - gx;
    dy = (gy > py) ? gy - py : py - gy;
    reach = gs + ps;
    return (dx < reach) && (dy < reach);
  endfunction

  // Compare process: advance model for the preceding rising edge, then check.
  always @(negedge frame_clk) begin
    if (Reset) begin
      m_e = 0; m_last = 0; m_has = 0; m_over = 0; m_lives = LIVES0;
      last_pulse_e = -100000;
    end else begin
      m_e++;
      m_ov = model_ov(int'(ghostX), int'(ghostY), int'(ghostS),
                      int'(pacX), int'(pacY), int'(pacS));
      if (!m_over && m_ov && (!m_has || (m_e - m_last) >= PERIOD)) begin
        m_has = 1; m_last = m_e; m_lives--;
        if (m_lives == 0) m_over = 1;
      end
    end
    exp_caught = m_has && (m_e == m_last);
    exp_freeze = m_over || (m_has && (m_e - m_last) < HOLD);
    chk("caught", int'(caught), int'(exp_caught));
    chk("freeze", int'(freeze), int'(exp_freeze));
    chk("lives", int'(lives), m_lives);
    chk("game_over", int'(game_over), int'(m_over));
    if (caught) begin
      pulses++;
      gap = m_e - last_pulse_e;
      last_pulse_e = m_e;
    end
  end

  task automatic tick();
    @(negedge frame_clk);
    #1;
  endtask

  task automatic place(input int gx, input int gy, input int gs,
                       input int px, input int py, input int ps);
    ghostX = 10'(gx); ghostY = 10'(gy); ghostS = 10'(gs);
    pacX   = 10'(px); pacY   = 10'(py); pacS   = 10'(ps);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  int p0, p1, len, off, mode;

  initial begin
    Reset = 1'b1;
    place(50, 50, 10, 200, 200, 10);
    tick();
    chk("rst_lives", int'(lives), 3);
    chk("rst_freeze", int'(freeze), 0);
    chk("rst_game_over", int'(game_over), 0);
    Reset = 1'b0;

    // Far apart: nothing happens.
    p0 = pulses;
    repeat (100) tick();
    chk("apart_pulses", pulses - p0, 0);
    chk("apart_lives", int'(lives), 3);
    chk("apart_freeze", int'(freeze), 0);

    // Touching edges is not an overlap.
    place(50, 50, 10, 70, 50, 10);
    repeat (5) tick();
    chk("touch_pulses", pulses - p0, 0);

    // One pixel closer catches.
    place(50, 50, 10, 69, 50, 10);
    tick();
    chk("catch1_caught", int'(caught), 1);
    chk("catch1_lives", int'(lives), 2);
    chk("catch1_freeze", int'(freeze), 1);
    place(50, 50, 10, 65, 50, 10);
    tick();
    chk("pulse_width", int'(caught), 0);
    chk("hold_freeze", int'(freeze), 1);
    for (int k = 2; k < PERIOD; k++) begin
      tick();
      if (k == HOLD - 1) chk("freeze_last", int'(freeze), 1);
      if (k == HOLD)     chk("freeze_end", int'(freeze), 0);
    end
    chk("no_grace_catch", pulses - p0, 1);
    tick();
    chk("recatch_caught", int'(caught), 1);
    chk("recatch_gap", gap, PERIOD);
    chk("recatch_lives", int'(lives), 1);

    // Third catch ends the game.
    repeat (PERIOD) tick();
    chk("over_lives", int'(lives), 0);
    chk("over_flag", int'(game_over), 1);
    chk("over_freeze", int'(freeze), 1);
    chk("over_gap", gap, PERIOD);
    p1 = pulses;
    repeat (30) tick();
    place(50, 50, 10, 400, 50, 10);
    repeat (30) tick();
    chk("over_pulses", pulses - p1, 0);
    chk("over_sticky_lives", int'(lives), 0);
    chk("over_sticky_flag", int'(game_over), 1);

    // Asynchronous reset in the middle of CAUGHT.
    do_reset();
    place(50, 50, 10, 65, 50, 10);
    tick();
    chk("pre_rst_catch", int'(caught), 1);
    repeat (20) tick();
    Reset = 1'b1;
    #1;
    chk("async_lives", int'(lives), 3);
    chk("async_freeze", int'(freeze), 0);
    chk("async_game_over", int'(game_over), 0);
    tick();
    Reset = 1'b0;
    tick();
    chk("post_rst_caught", int'(caught), 1);
    chk("post_rst_lives", int'(lives), 2);

    // Random positions and sizes, occasional resets.
    for (int s = 0; s < 60; s++) begin
      mode = int'($urandom_range(0, 3));
      ghostX = 10'($urandom);
      ghostY = 10'($urandom);
      ghostS = (mode == 0) ? 10'($urandom) : 10'($urandom_range(0, 30));
      pacS   = (mode == 0) ? 10'($urandom) : 10'($urandom_range(0, 30));
      off  = int'($urandom_range(0, 80)) - 40;
      pacX = 10'(int'(ghostX) + off);
      off  = int'($urandom_range(0, 80)) - 40;
      pacY = 10'(int'(ghostY) + off);
      if ($urandom_range(0, 9) == 0) do_reset();
      len = int'($urandom_range(1, 100));
      for (int f = 0; f < len; f++) begin
        if ($urandom_range(0, 3) == 0) begin
          off  = int'($urandom_range(0, 6)) - 3;
          pacX = 10'(int'(pacX) + off);
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
